ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers. Consumes the
//  ID/EX control fields md_is_mult/md_is_unsigned plus lhr_wen/lhr_is_hi/lhr_is_mult, and
//  operands from the EX forwarding muxes. Drives busy to the hazard unit, which stalls
//  IF/ID/EX while an operation runs. HI/LO read data goes to the WB write-data mux (mfhi/mflo).
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//  clk             in   1      single clock; all state updates on posedge
//  rst             in   1      synchronous reset, active-high
//  clr             in   1      pipeline flush; aborts any running operation
//  start           in   1      launch op (EX-valid mult/div instruction)
//  md_is_mult      in   1      1 = multiply, 0 = divide (sampled with start)
//  md_is_unsigned  in   1      1 = unsigned operands (sampled with start)
//  op_a            in   WIDTH  rs operand / dividend
//  op_b            in   WIDTH  rt operand / divisor
//  lhr_wen         in   1      mthi/mtlo write strobe
//  lhr_is_hi       in   1      1 = target HI, 0 = target LO
//  lhr_wdata       in   WIDTH  mthi/mtlo data
//  busy            out  1      operation in progress
//  done            out  1      one-cycle pulse: HI/LO just updated by an op
//  hi              out  WIDTH  HI register
//  lo              out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-op abandons it.
//  - FSM: IDLE -> CALC (start && !clr) ; CALC -> CALC for 32 steps (counter 31..0) ;
//    CALC -> SIGN when counter==0 ; SIGN -> IDLE. clr in CALC/SIGN -> IDLE, HI/LO unchanged.
//  - busy = (state != IDLE), registered. start sampled at edge N: busy=1 after edges N..N+32,
//    HI/LO written and done=1 at edge N+33, busy=0 same edge. Latency 33 cycles, fixed.
//  - Operands/flags latched at start; later changes to op_a/op_b ignored.
//  - start while busy: ignored (hazard unit must not issue it). start in SIGN not accepted.
//  - Multiply: shift-add on magnitudes, 1 bit/cycle; 2*WIDTH product; HI=upper, LO=lower.
//    Signed: magnitudes taken at start, product negated in SIGN if signs differ.
//  - Divide: restoring, 1 quotient bit/cycle; LO=quotient, HI=remainder. Signed: quotient
//    truncates toward zero, remainder takes dividend sign.
//  - Divide by zero: LO=all ones, HI=op_a (both signed and unsigned); full 33-cycle latency.
//  - Signed overflow (-2^31 / -1): LO=0x80000000, HI=0.
//  - lhr_wen in IDLE: writes HI or LO next edge, other register unchanged, done stays 0.
//    lhr_wen while busy: dropped. lhr_wen && start same cycle: start wins, write dropped.
//  - clr and start same cycle: no launch; clr with lhr_wen: write dropped.
//  - done never asserts for aborted ops; done and busy never both 1.
// STRUCTURE
//  - Shared header mips_defs.vh: MD_IDLE/MD_CALC/MD_SIGN state codes, MD_STEPS=32 constant.
//  - One sub-module md_step_core: combinational single iteration (add-shift for mult,
//    trial-subtract-shift for div) on {rem/acc, quotient/multiplier} registers; FSM,
//    counter, sign fix-up and HI/LO live in ex_muldiv_unit.
// TESTING
//  1 multu 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done 1 cycle
//  2 mult -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles
//  3 div -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 100/0 -> LO=0xFFFFFFFF, HI=100
//  4 div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; divu 0x80000000/0xFFFFFFFF -> LO=0, HI=0x80000000
//  5 start mult, clr at cycle 10 -> busy=0 next cycle, done never pulses, HI/LO keep prior values
//  6 mthi 0x1234 in IDLE -> HI=0x1234, LO unchanged; mtlo during busy -> dropped; rst at cycle 5 -> all 0

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared state codes and step count for the EX multiply/divide unit
package ex_muldiv_unit_pkg;
  localparam int MD_STEPS = 32;
  localparam int MD_CNT_W = $clog2(MD_STEPS);
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_SIGN = 2'd2
  } md_state_t;
endpackage

// File: rtl/ex_muldiv_unit_step_core.sv
// ex_muldiv_unit_step_core: one combinational add-shift (mult) or trial-subtract-shift (div) iteration
module md_step_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_mult,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] sum, rem_t, diff;
  always_comb begin
    sum   = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    rem_t = {acc, q[WIDTH-1]};
    diff  = rem_t - {1'b0, b};
    acc_n = is_mult ? sum[WIDTH:1] : (diff[WIDTH] ? rem_t[WIDTH-1:0] : diff[WIDTH-1:0]);
    q_n   = is_mult ? {sum[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~diff[WIDTH]};
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: 33-cycle multiply/divide unit with HI/LO registers and mthi/mtlo writes
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             md_is_mult,
  input  logic             md_is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             lhr_wen,
  input  logic             lhr_is_hi,
  input  logic [WIDTH-1:0] lhr_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t state, state_n;
  logic [MD_CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, b, acc_n, q_n, a_mag, b_mag, quo, rem, hi_res, lo_res;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic mult, neg_q, neg_r, sa, sb, launch, finish;
  md_step_core #(.WIDTH(WIDTH)) u_step (
    .is_mult(mult),
    .acc(acc),
    .q(q),
    .b(b),
    .acc_n(acc_n),
    .q_n(q_n)
  );
  assign busy   = state != MD_IDLE;
  assign launch = state == MD_IDLE && start && !clr;
  assign finish = state == MD_SIGN && !clr;
  always_comb begin
    state_n = clr ? MD_IDLE
            : state == MD_IDLE ? (start ? MD_CALC : MD_IDLE)
            : state == MD_CALC ? (cnt == '0 ? MD_SIGN : MD_CALC)
            : MD_IDLE;
  end
  always_ff @(posedge clk) state <= rst ? MD_IDLE : state_n;
  always_comb begin
    sa     = !md_is_unsigned && op_a[WIDTH-1];
    sb     = !md_is_unsigned && op_b[WIDTH-1];
    a_mag  = sa ? -op_a : op_a;
    b_mag  = sb ? -op_b : op_b;
    prod   = {acc, q};
    prod_f = neg_q ? -prod : prod;
    // divide by zero leaves acc = |a|, so the remainder fix-up alone restores HI = op_a
    quo    = b == '0 ? '1 : (neg_q ? -q : q);
    rem    = neg_r ? -acc : acc;
    hi_res = mult ? prod_f[2*WIDTH-1:WIDTH] : rem;
    lo_res = mult ? prod_f[WIDTH-1:0] : quo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      b     <= '0;
      mult  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= finish;
      if (launch) begin
        cnt   <= MD_CNT_W'(MD_STEPS - 1);
        acc   <= '0;
        q     <= a_mag;
        b     <= b_mag;
        mult  <= md_is_mult;
        neg_q <= sa ^ sb;
        neg_r <= sa && !md_is_mult;
      end else if (state == MD_CALC) begin
        cnt <= cnt - 1'b1;
        acc <= acc_n;
        q   <= q_n;
      end
      if (finish) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (state == MD_IDLE && lhr_wen && !start && !clr) begin
        if (lhr_is_hi) hi <= lhr_wdata;
        else lo <= lhr_wdata;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized self-checking bench against an arithmetic reference model
module tb_ex_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, start = 1'b0;
  logic md_is_mult = 1'b0, md_is_unsigned = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, lhr_wdata = '0;
  logic lhr_wen = 1'b0, lhr_is_hi = 1'b0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .md_is_mult(md_is_mult), .md_is_unsigned(md_is_unsigned),
    .op_a(op_a), .op_b(op_b),
    .lhr_wen(lhr_wen), .lhr_is_hi(lhr_is_hi), .lhr_wdata(lhr_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sp;
    longint unsigned up;
    int ia, ib;
    ia = a;
    ib = b;
    if (m) begin
      up = longint'(a) * longint'(b);
      sp = longint'(ia) * longint'(ib);
      {eh, el} = u ? up : sp;
    end else if (b == 0) begin
      el = 32'hFFFF_FFFF;
      eh = a;
    end else if (u) begin
      el = a / b;
      eh = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      el = 32'h8000_0000;
      eh = 32'h0;
    end else begin
      el = ia / ib;
      eh = ia % ib;
    end
  endfunction
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s: busy still %b after %0d cycles, want 0", name, busy, n);
    end
  endtask
  task automatic do_op(input bit m, input bit u, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, input string name);
    logic [31:0] eh, el;
    int bc = 0;
    model(m, u, a, b, eh, el);
    md_is_mult = m;
    md_is_unsigned = u;
    op_a = a;
    op_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    md_is_mult = 1'($urandom);
    md_is_unsigned = 1'($urandom);
    while (busy && bc < 40) begin
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_busy: done=%b with busy=1 at cycle %0d, want 0", name, done, bc);
      end
      start = poke && bc == 5;
      tick();
      bc++;
    end
    start = 1'b0;
    checks++;
    if (bc !== 33) begin
      failures++;
      $display("FAIL %s_latency: busy cycles=%0d, want 33", name, bc);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b, want 1", name, done);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL %s_result: a=%h b=%h got hi=%h lo=%h, want hi=%h lo=%h", name, a, b, hi, lo, eh, el);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", name, done);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
  endtask
  task automatic test_directed();
    do_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    do_op(1, 0, -32'sd7, 32'd3, 0, "mult_neg");
    do_op(0, 0, -32'sd7, 32'd2, 0, "div_neg");
    do_op(0, 1, 32'd100, 32'd0, 0, "divu_zero");
    do_op(0, 0, -32'sd100, 32'd0, 0, "div_zero_neg");
    do_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_big");
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, "mult_minmin");
    do_op(0, 0, 32'd7, -32'sd2, 0, "div_negdiv");
  endtask
  task automatic test_random();
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom >> $urandom_range(0, 31);
      do_op(1'(i % 2), 1'($urandom), a, b, 0, "rand");
    end
  endtask
  task automatic test_start_while_busy();
    do_op(1, 0, $urandom, $urandom, 1, "poke_mult");
    do_op(0, 1, $urandom, $urandom_range(1, 1000), 1, "poke_divu");
  endtask
  task automatic test_abort();
    logic [31:0] sh, sl;
    bit seen = 0;
    do_op(1, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, "pre_abort");
    sh = hi;
    sl = lo;
    md_is_mult = 1'b1;
    op_a = $urandom;
    op_b = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: busy=%b after clr, want 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      seen |= done;
      tick();
    end
    checks++;
    if (seen || hi !== sh || lo !== sl) begin
      failures++;
      $display("FAIL abort_hold: done_seen=%b hi=%h lo=%h, want 0 %h %h", seen, hi, lo, sh, sl);
    end
    clr = 1'b1;
    start = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_start: busy=%b, want 0", busy);
    end
  endtask
  task automatic test_lhr();
    logic [31:0] sl, sh;
    sl = lo;
    lhr_wen = 1'b1;
    lhr_is_hi = 1'b1;
    lhr_wdata = 32'h1234;
    tick();
    lhr_wen = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== sl || done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h done=%b, want 00001234 %h 0", hi, lo, done, sl);
    end
    lhr_wen = 1'b1;
    lhr_is_hi = 1'b0;
    lhr_wdata = 32'h55AA;
    tick();
    lhr_wen = 1'b0;
    checks++;
    if (lo !== 32'h55AA || hi !== 32'h1234) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h, want 00001234 000055aa", hi, lo);
    end
    md_is_mult = 1'b1;
    op_a = 32'd3;
    op_b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    lhr_wen = 1'b1;
    lhr_wdata = 32'hDEAD;
    tick();
    lhr_wen = 1'b0;
    checks++;
    if (lo !== 32'h55AA) begin
      failures++;
      $display("FAIL mtlo_busy: lo=%h, want 000055aa", lo);
    end
    wait_idle("mtlo_busy_wait");
    sh = hi;
    start = 1'b1;
    lhr_wen = 1'b1;
    lhr_is_hi = 1'b1;
    lhr_wdata = ~sh;
    tick();
    start = 1'b0;
    lhr_wen = 1'b0;
    checks++;
    if (hi !== sh || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_vs_mthi: hi=%h busy=%b, want %h 1", hi, busy, sh);
    end
    wait_idle("start_vs_mthi_wait");
    tick();
    sh = hi;
    clr = 1'b1;
    lhr_wen = 1'b1;
    lhr_wdata = ~sh;
    tick();
    clr = 1'b0;
    lhr_wen = 1'b0;
    checks++;
    if (hi !== sh) begin
      failures++;
      $display("FAIL clr_mthi: hi=%h, want %h", hi, sh);
    end
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    md_is_mult = 1'b0;
    op_a = $urandom;
    op_b = $urandom_range(1, 99);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    for (int i = 0; i < 40; i++) begin
      seen |= done | busy;
      tick();
    end
    checks++;
    if (seen || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_quiet: activity=%b hi=%h lo=%h, want 0 0 0", seen, hi, lo);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_op(1'($urandom), 1'($urandom), $urandom, $urandom >> $urandom_range(0, 31), 0, "b2b");
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_abort();
    test_lhr();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
